// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store unit in front of a word-addressed data memory
//
// Purpose: accepts one load or store request at a time from the datapath and
// drives the data memory's MemRead/MemWrite/Address/WriteData port. Sub-word
// stores are done as read-modify-write because the memory only writes whole
// words. Loads are returned sign- or zero-extended.
//
// Ports:
//   Clk, reset         clock, asynchronous active-high reset
//   req_valid/ready    request handshake (ready only in IDLE)
//   req_write          1 = store, 0 = load
//   req_size           00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned       loads only: 1 = zero-extend
//   req_addr/wdata     byte address, right-aligned store data
//   resp_valid         one-cycle completion pulse
//   resp_rdata/err     extended load data, error flag
//   MemRead/MemWrite   memory strobes, one cycle per access
//   Address/WriteData  word index and write word
//   ReadData           memory read data, sampled at the end of a MemRead cycle

module load_store_unit #(
    parameter int DEPTH = 32,
    parameter int IDX_W = 5
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Address,
    output logic [31:0] WriteData,
    input  logic [31:0] ReadData
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD     = 3'd1;
    localparam logic [2:0] S_WR     = 3'd2;
    localparam logic [2:0] S_RMW_RD = 3'd3;
    localparam logic [2:0] S_RMW_WR = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    logic [2:0]  state_q, state_d;
    logic        ready_q, ready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rerr_q, rerr_d;
    logic        mread_q, mread_d;
    logic        mwrite_q, mwrite_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdo_q, wdo_d;

    // Request fields latched at acceptance for use in later states.
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  lo_q, lo_d;
    logic [15:0] sub_q, sub_d;

    logic        idx_oob;
    logic        req_bad;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;
    logic [31:0] merged;

    // Out of range when any bit above the index is set, or the index itself
    // reaches DEPTH (covers non-power-of-two memories).
    assign idx_oob = (|req_addr[31:IDX_W+2]) ||
                     ({1'b0, req_addr[IDX_W+1:2]} >= (IDX_W+1)'(DEPTH));

    always_comb begin
        req_bad = 1'b0;
        case (req_size)
            SIZE_B:  req_bad = 1'b0;
            SIZE_H:  req_bad = req_addr[0];
            SIZE_W:  req_bad = |req_addr[1:0];
            default: req_bad = 1'b1;
        endcase
        req_bad = req_bad | idx_oob;
    end

    // Little-endian lane selection from the returned word.
    always_comb begin
        lane_b = ReadData[7:0];
        case (lo_q)
            2'd0:    lane_b = ReadData[7:0];
            2'd1:    lane_b = ReadData[15:8];
            2'd2:    lane_b = ReadData[23:16];
            default: lane_b = ReadData[31:24];
        endcase
        lane_h = lo_q[1] ? ReadData[31:16] : ReadData[15:0];
    end

    always_comb begin
        load_ext = ReadData;
        case (size_q)
            SIZE_B:  load_ext = uns_q ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
            SIZE_H:  load_ext = uns_q ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_ext = ReadData;
        endcase
    end

    // Read-modify-write merge: the fetched word with only the addressed lane replaced.
    always_comb begin
        merged = ReadData;
        case (size_q)
            SIZE_B: begin
                case (lo_q)
                    2'd0:    merged[7:0]   = sub_q[7:0];
                    2'd1:    merged[15:8]  = sub_q[7:0];
                    2'd2:    merged[23:16] = sub_q[7:0];
                    default: merged[31:24] = sub_q[7:0];
                endcase
            end
            SIZE_H: begin
                if (lo_q[1]) begin
                    merged[31:16] = sub_q;
                end else begin
                    merged[15:0] = sub_q;
                end
            end
            default: merged = ReadData;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ready_d  = ready_q;
        rvalid_d = 1'b0;
        rdata_d  = 32'd0;
        rerr_d   = 1'b0;
        mread_d  = 1'b0;
        mwrite_d = 1'b0;
        addr_d   = addr_q;
        wdo_d    = wdo_q;
        size_d   = size_q;
        uns_d    = uns_q;
        lo_d     = lo_q;
        sub_d    = sub_q;
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (req_valid && ready_q) begin
                    ready_d = 1'b0;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    lo_d    = req_addr[1:0];
                    sub_d   = req_wdata[15:0];
                    if (req_bad) begin
                        state_d  = S_RESP;
                        rvalid_d = 1'b1;
                        rerr_d   = 1'b1;
                    end else begin
                        addr_d = {2'b00, req_addr[31:2]};
                        if (!req_write) begin
                            state_d = S_RD;
                            mread_d = 1'b1;
                        end else if (req_size == SIZE_W) begin
                            state_d  = S_WR;
                            mwrite_d = 1'b1;
                            wdo_d    = req_wdata;
                        end else begin
                            state_d = S_RMW_RD;
                            mread_d = 1'b1;
                        end
                    end
                end
            end
            S_RD: begin
                state_d  = S_RESP;
                rvalid_d = 1'b1;
                rdata_d  = load_ext;
            end
            S_WR: begin
                state_d  = S_RESP;
                rvalid_d = 1'b1;
            end
            S_RMW_RD: begin
                // WriteData is registered from the merge, so it doubles as
                // the latch of the fetched word.
                state_d  = S_RMW_WR;
                mwrite_d = 1'b1;
                wdo_d    = merged;
            end
            S_RMW_WR: begin
                state_d  = S_RESP;
                rvalid_d = 1'b1;
            end
            S_RESP: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
            rerr_q   <= 1'b0;
            mread_q  <= 1'b0;
            mwrite_q <= 1'b0;
            addr_q   <= 32'd0;
            wdo_q    <= 32'd0;
            size_q   <= 2'b00;
            uns_q    <= 1'b0;
            lo_q     <= 2'b00;
            sub_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
            mread_q  <= mread_d;
            mwrite_q <= mwrite_d;
            addr_q   <= addr_d;
            wdo_q    <= wdo_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            lo_q     <= lo_d;
            sub_q    <= sub_d;
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = rvalid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = rerr_q;
    assign MemRead    = mread_q;
    assign MemWrite   = mwrite_q;
    assign Address    = addr_q;
    assign WriteData  = wdo_q;

endmodule
